// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : reg_scoreboard
// Purpose  : Issue-side hazard controller for the 32x32-bit register file.
//            Keeps a small counter of in-flight writes per destination
//            register and blocks issue while a source register has an
//            outstanding write (RAW) or while the destination counter is
//            already full (SAT). Counters are released by write-back,
//            including writes that the register file later suppresses.
//
// Ports    :
//   Clk          in   clock, all state updates on rising edge
//   Rst_n        in   synchronous active-low reset (highest priority)
//   Run          in   global run enable; low freezes all state
//   Flush        in   clear every outstanding-write counter
//   Issue_Valid  in   instruction presented for issue
//   Issue_Rs/Rt  in   source registers A/B
//   Issue_UseRs  in   instruction reads Rs
//   Issue_UseRt  in   instruction reads Rt
//   Issue_WrEn   in   instruction writes a register
//   Issue_Rw     in   resolved destination register
//   Wb_Valid     in   a write-back retires this cycle
//   Wb_Rw        in   retiring destination register
//   Stall        out  issue blocked this cycle (combinational)
//   Busy         out  bit i set while register i has outstanding writes
//   Idle         out  no outstanding writes anywhere
//   Err          out  sticky: write-back retired an untracked register
//
// Revision : 1.0  initial release
// ============================================================================
module reg_scoreboard #(
    parameter int CNT_W = 2,
    parameter int NREG  = 32
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic            Run,
    input  logic            Flush,
    input  logic            Issue_Valid,
    input  logic [4:0]      Issue_Rs,
    input  logic [4:0]      Issue_Rt,
    input  logic            Issue_UseRs,
    input  logic            Issue_UseRt,
    input  logic            Issue_WrEn,
    input  logic [4:0]      Issue_Rw,
    input  logic            Wb_Valid,
    input  logic [4:0]      Wb_Rw,
    output logic            Stall,
    output logic [NREG-1:0] Busy,
    output logic            Idle,
    output logic            Err
);

    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [4:0]       c_R0       = 5'd0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // Entry 0 is reset to zero and never updated, so register 0 always
    // reads as free and never produces a hazard.
    logic [CNT_W-1:0] r_cnt [NREG];
    logic             r_err;

    // ------------------------------------------------------------------
    // Hazard detection (pre-edge counters only: a write-back in the same
    // cycle does not unblock issue)
    // ------------------------------------------------------------------
    logic w_raw_rs;
    logic w_raw_rt;
    logic w_sat;
    logic w_stall;
    logic w_accept;

    always_comb begin
        w_raw_rs = Issue_UseRs && (Issue_Rs != c_R0) && (r_cnt[Issue_Rs] != c_CNT_ZERO);
        w_raw_rt = Issue_UseRt && (Issue_Rt != c_R0) && (r_cnt[Issue_Rt] != c_CNT_ZERO);
        // A full counter cannot take another write; stalling here is what
        // keeps the counter from ever wrapping.
        w_sat    = Issue_WrEn && (Issue_Rw != c_R0) && (r_cnt[Issue_Rw] == c_CNT_MAX);
        w_stall  = Flush || !Run || (Issue_Valid && (w_raw_rs || w_raw_rt || w_sat));
        w_accept = Run && !Flush && Issue_Valid && !w_stall;
    end

    assign Stall = w_stall;

    // ------------------------------------------------------------------
    // Per-register increment / decrement requests
    // ------------------------------------------------------------------
    logic            w_inc_en;
    logic            w_wb_live;
    logic            w_dec_en;
    logic            w_err_set;
    logic [NREG-1:0] w_inc_vec;
    logic [NREG-1:0] w_dec_vec;

    always_comb begin
        w_inc_en  = w_accept && Issue_WrEn && (Issue_Rw != c_R0);
        w_wb_live = Run && !Flush && Wb_Valid && (Wb_Rw != c_R0);
        // Underflow is turned into an error flag instead of a decrement.
        w_dec_en  = w_wb_live && (r_cnt[Wb_Rw] != c_CNT_ZERO);
        w_err_set = w_wb_live && (r_cnt[Wb_Rw] == c_CNT_ZERO);

        w_inc_vec = '0;
        w_dec_vec = '0;
        if (w_inc_en) begin
            w_inc_vec[Issue_Rw] = 1'b1;
        end
        if (w_dec_en) begin
            w_dec_vec[Wb_Rw] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Counter update. Priority: reset, flush, run-freeze, then the
    // increment/decrement pair. A simultaneous increment and decrement of
    // the same register cancel out.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i] <= c_CNT_ZERO;
            end
        end else if (Flush) begin
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i] <= c_CNT_ZERO;
            end
        end else if (Run) begin
            for (int i = 1; i < NREG; i++) begin
                case ({w_inc_vec[i], w_dec_vec[i]})
                    2'b10:   r_cnt[i] <= r_cnt[i] + c_CNT_ONE;
                    2'b01:   r_cnt[i] <= r_cnt[i] - c_CNT_ONE;
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end
        end
    end

    // Sticky error: only reset clears it; flush leaves it alone.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    assign Err = r_err;

    // ------------------------------------------------------------------
    // Status outputs, derived from registered counters only
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < NREG; g++) begin : g_busy
            assign Busy[g] = (r_cnt[g] != c_CNT_ZERO);
        end
    endgenerate

    assign Idle = ~|Busy;

endmodule
`default_nettype wire
